// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio constants and I2S receiver state encoding
package audio_pkg;

  localparam int AUDIO_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_sync_ff.sv
// rtl/i2s_rx_sync_ff.sv - single-bit flip-flop synchroniser chain of configurable depth
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver: brings codec clocks into clk and assembles left/right samples
module i2s_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = AUDIO_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                l_r_clk,
  input  logic                sdin,
  output logic [SAMPLE_W-1:0] audio_left,
  output logic [SAMPLE_W-1:0] audio_right,
  output logic                sample_valid,
  output logic                frame_err
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_W);

  logic                sclk_s, lr_s, sd_s;
  logic                sclk_q, lr_prev;
  logic                sclk_rise, lr_change;
  i2s_rx_state_t       state;
  logic [SAMPLE_W-1:0] shift_reg, hold_left, final_reg, word;
  logic [CNT_W-1:0]    bit_cnt, final_cnt;
  logic                final_short, left_ok, from_idle;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_sclk (.clk(clk), .reset(reset), .d(sclk),    .q(sclk_s));
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_lr   (.clk(clk), .reset(reset), .d(l_r_clk), .q(lr_s));
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_sd   (.clk(clk), .reset(reset), .d(sdin),    .q(sd_s));

  assign sclk_rise = sclk_s & ~sclk_q;
  assign lr_change = lr_s ^ lr_prev;

  // The bit sampled at the word-select change is the LSB of the word that is ending.
  always_comb begin
    final_reg = shift_reg;
    final_cnt = bit_cnt;
    if (bit_cnt < CNT_FULL) begin
      final_reg = {shift_reg[SAMPLE_W-2:0], sd_s};
      final_cnt = bit_cnt + CNT_W'(1);
    end
    final_short = final_cnt < CNT_FULL;
    word        = final_reg << (CNT_FULL - final_cnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q       <= 1'b0;
      lr_prev      <= 1'b0;
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      hold_left    <= '0;
      left_ok      <= 1'b0;
      from_idle    <= 1'b0;
      audio_left   <= '0;
      audio_right  <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sclk_q       <= sclk_s;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (sclk_rise) begin
        lr_prev <= lr_s;
        if (lr_change) begin
          if (state != IDLE) begin
            frame_err <= final_short;
            // A truncated word from the slot that woke us from IDLE is never trusted.
            if (!(from_idle && final_short)) begin
              if (!lr_prev) begin
                hold_left <= word;
                left_ok   <= 1'b1;
              end else if (left_ok) begin
                audio_left   <= hold_left;
                audio_right  <= word;
                sample_valid <= 1'b1;
                left_ok      <= 1'b0;
              end
            end
          end
          state     <= SHIFT;
          shift_reg <= '0;
          bit_cnt   <= '0;
          from_idle <= (state == IDLE);
        end else if (state == SHIFT) begin
          shift_reg <= {shift_reg[SAMPLE_W-2:0], sd_s};
          bit_cnt   <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_FULL - CNT_W'(1)) state <= HOLD;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - randomized scoreboard bench for i2s_rx against a slot-level reference model
module tb_i2s_rx;

  localparam int W    = 16;
  localparam int SYNC = 2;
  localparam int HALF = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sclk = 1'b0;
  logic         l_r_clk = 1'b0;
  logic         sdin = 1'b0;
  logic [W-1:0] audio_left, audio_right;
  logic         sample_valid, frame_err;

  always #5 clk = ~clk;

  i2s_rx #(.SAMPLE_W(W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .l_r_clk(l_r_clk), .sdin(sdin),
    .audio_left(audio_left), .audio_right(audio_right),
    .sample_valid(sample_valid), .frame_err(frame_err)
  );

  typedef struct { logic ch; int len; logic [63:0] data; } slot_t;
  typedef struct packed { logic [W-1:0] l; logic [W-1:0] r; } frame_t;

  slot_t  slots[$];
  frame_t exp_q[$];
  frame_t exp_f;
  int     checks = 0, errors = 0;
  int     cyc = 0, rl_edge_cyc = 0;
  int     valid_seen = 0, ferr_seen = 0, exp_valid = 0, exp_ferr = 0;
  logic   prev_valid = 1'b0;
  logic   drv_lr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a sample.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_err) ferr_seen++;
      if (sample_valid) begin
        valid_seen++;
        chk("valid_width", prev_valid, 0);
        chk("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_f = exp_q.pop_front();
          chk("audio_left", audio_left, exp_f.l);
          chk("audio_right", audio_right, exp_f.r);
          // cycle in which a downstream flop captures sample_valid, counted from the sclk edge
          chk("latency", cyc - rl_edge_cyc + 1, SYNC + 2);
        end
      end
    end
    prev_valid = sample_valid;
  end

  function automatic logic [63:0] rnd(input int len);
    logic [63:0] v;
    v = {$urandom, $urandom};
    if (len < 64) v = v & ((64'd1 << len) - 64'd1);
    return v;
  endfunction

  function automatic logic [63:0] mk(input logic [15:0] v, input int len);
    return (64'(v) << (len - 16)) | rnd(len - 16);
  endfunction

  task automatic add_slot(input logic c, input int l, input logic [63:0] d);
    slots.push_back('{ch: c, len: l, data: d});
  endtask

  // Reference: each slot yields its first min(len,W) bits, left-justified; short slots flag an error.
  task automatic build_expect(input bit flush);
    logic         ok;
    logic [W-1:0] hold, word;
    logic [63:0]  top;
    int           last, nb;
    ok = 1'b0;
    hold = '0;
    last = flush ? slots.size() : slots.size() - 1;
    for (int i = 0; i < last; i++) begin
      nb   = (slots[i].len < W) ? slots[i].len : W;
      top  = slots[i].data >> (slots[i].len - nb);
      word = W'(top << (W - nb));
      if (nb < W) exp_ferr++;
      if (slots[i].ch == 1'b0) begin
        hold = word;
        ok = 1'b1;
      end else if (ok) begin
        exp_q.push_back({hold, word});
        exp_valid++;
        ok = 1'b0;
      end
    end
  endtask

  task automatic drive_period(input logic lr, input logic sd);
    @(negedge clk);
    sclk = 1'b0;
    l_r_clk = lr;
    sdin = sd;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    if (lr == 1'b0 && drv_lr == 1'b1) rl_edge_cyc = cyc;
    drv_lr = lr;
    repeat (HALF - 1) @(negedge clk);
  endtask

  task automatic play_slots(input bit flush);
    logic last_bit, last_ch;
    last_bit = 1'b0;
    last_ch = drv_lr;
    foreach (slots[i]) begin
      for (int k = 0; k < slots[i].len; k++)
        drive_period(slots[i].ch, (k == 0) ? last_bit : slots[i].data[slots[i].len - k]);
      last_bit = slots[i].data[0];
      last_ch = slots[i].ch;
    end
    if (flush) drive_period(~last_ch, last_bit);
  endtask

  task automatic do_reset(input logic lr);
    @(negedge clk);
    reset = 1'b0;
    sclk = 1'b0;
    l_r_clk = lr;
    sdin = 1'b0;
    drv_lr = lr;
    repeat (3) @(negedge clk);
    exp_q.delete();
    valid_seen = 0;
    ferr_seen = 0;
    exp_valid = 0;
    exp_ferr = 0;
    reset = 1'b1;
  endtask

  task automatic run_scenario(input string name, input bit flush);
    build_expect(flush);
    play_slots(flush);
    repeat (20) @(negedge clk);
    chk({name, "_valid_count"}, valid_seen, exp_valid);
    chk({name, "_ferr_count"}, ferr_seen, exp_ferr);
    chk({name, "_leftover"}, exp_q.size(), 0);
  endtask

  function automatic int rand_len();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(16, 32));
  endfunction

  int          len, base;
  logic [63:0] d;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_left", audio_left, 0);
    chk("rst_right", audio_right, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ferr", frame_err, 0);

    do_reset(1'b0);
    slots.delete();
    add_slot(1'b1, 32, rnd(32));
    add_slot(1'b0, 32, mk(16'h1234, 32));
    add_slot(1'b1, 32, mk(16'hABCD, 32));
    run_scenario("basic", 1'b1);
    chk("basic_left", audio_left, 16'h1234);
    chk("basic_right", audio_right, 16'hABCD);

    do_reset(1'b0);
    slots.delete();
    add_slot(1'b1, 32, rnd(32));
    add_slot(1'b0, 32, rnd(32));
    add_slot(1'b1, 32, mk(16'h8000, 32));
    run_scenario("sign", 1'b1);
    chk("signed_right", $signed(audio_right), -32768);

    do_reset(1'b0);
    slots.delete();
    add_slot(1'b1, 32, rnd(32));
    add_slot(1'b0, 8, 64'hA5);
    add_slot(1'b1, 32, mk(16'h5A5A, 32));
    run_scenario("short", 1'b1);
    chk("short_left", audio_left, 16'hA500);

    do_reset(1'b1);
    slots.delete();
    add_slot(1'b1, 10, rnd(10));
    add_slot(1'b0, 32, rnd(32));
    add_slot(1'b1, 32, rnd(32));
    run_scenario("midright", 1'b1);

    do_reset(1'b0);
    slots.delete();
    base = $urandom_range(0, 1000);
    add_slot(1'b1, 32, rnd(32));
    for (int f = 0; f < 4; f++) begin
      add_slot(1'b0, 32, mk(16'(base + 2 * f), 32));
      add_slot(1'b1, 32, mk(16'(base + 2 * f + 1), 32));
    end
    run_scenario("b2b", 1'b1);
    chk("b2b_pulses", valid_seen, 4);

    for (int s = 0; s < 4; s++) begin
      do_reset(1'b0);
      slots.delete();
      add_slot(1'b1, 32, rnd(32));
      for (int f = 0; f < 6; f++) begin
        len = rand_len();
        d = rnd(len);
        add_slot(f[0], len, d);
      end
      run_scenario("random", 1'b1);
    end

    do_reset(1'b0);
    slots.delete();
    add_slot(1'b1, 32, rnd(32));
    add_slot(1'b0, 32, mk(16'h7A5C, 32));
    add_slot(1'b1, 32, mk(16'h0F0F, 32));
    add_slot(1'b0, 5, rnd(5));
    run_scenario("async", 1'b0);
    chk("pre_reset_nonzero", audio_left != 0, 1);
    #($urandom_range(1, 4));
    reset = 1'b0;
    #1;
    chk("async_left", audio_left, 0);
    chk("async_right", audio_right, 0);
    chk("async_valid", sample_valid, 0);
    chk("async_ferr", frame_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter: SAMPLE_W, default 16, sample width in bits delivered to the filter stage.
REQ-002 Parameter: SYNC_STAGES, default 2, synchroniser depth for every asynchronous input.
REQ-003 Port: clk  input  1  system clock; the only clock in the block.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: sclk  input  1  I2S bit clock from the codec; asynchronous to clk.
REQ-006 Port: l_r_clk  input  1  I2S word select (0 = left, 1 = right); asynchronous.
REQ-007 Port: sdin  input  1  I2S serial data, MSB first, one-bit delay after each l_r_clk edge.
REQ-008 Port: audio_left  output  SAMPLE_W  signed left sample of the last complete frame.
REQ-009 Port: audio_right  output  SAMPLE_W  signed right sample of the last complete frame.
REQ-010 Port: sample_valid  output  1  one-clk pulse when audio_left and audio_right update.
REQ-011 Port: frame_err  output  1  one-clk pulse when a committed slot held fewer than SAMPLE_W bits.

Function
REQ-012 sclk, l_r_clk and sdin SHALL each pass through a SYNC_STAGES flip-flop chain of identical depth, so all three stay mutually aligned.
REQ-013 sclk_rise SHALL be a one-clk strobe asserted when the synchronised sclk is 1 and its previous-cycle value is 0.
REQ-014 All state changes except reset SHALL occur only in cycles with sclk_rise; clk SHALL be at least 4x the sclk frequency, which the block does not check.
REQ-015 The FSM SHALL have the states IDLE, SHIFT and HOLD; reset enters IDLE.
REQ-016 IDLE SHALL ignore sdin until the first sclk_rise at which the synchronised l_r_clk differs from its value at the previous sclk_rise; it then enters SHIFT with bit_cnt=0 for the new channel.
REQ-017 In SHIFT, each sclk_rise without an l_r_clk change SHALL shift sdin into the LSB of shift_reg and increment bit_cnt; at bit_cnt=SAMPLE_W the FSM SHALL enter HOLD.
REQ-018 In HOLD, sdin SHALL be discarded until the l_r_clk change, because slots wider than SAMPLE_W are truncated.
REQ-019 At an sclk_rise with an l_r_clk change, the sdin bit SHALL belong to the ending word; it is shifted in only if bit_cnt<SAMPLE_W, and the word is then committed.
REQ-020 The committed word SHALL be shift_reg shifted left by (SAMPLE_W - bit_cnt), so short words are left-justified and zero-filled.
REQ-021 frame_err SHALL pulse in the commit cycle+1 if the final bit_cnt<SAMPLE_W; a short word from a slot entered via IDLE SHALL still be discarded.
REQ-022 A committed left word SHALL go to a holding register and set left_ok; a committed right word with left_ok=1 SHALL load audio_left from the holding register and audio_right together.
REQ-023 Under REQ-022, sample_valid SHALL pulse in the cycle after that sclk_rise, and left_ok SHALL then clear.
REQ-024 A right word committed with left_ok=0 SHALL be dropped with no pulse.
REQ-025 Every commit SHALL return the FSM to SHIFT with bit_cnt=0 for the new channel.
REQ-026 Latency SHALL be fixed: SYNC_STAGES+2 clk cycles from the sclk edge at the right-to-left l_r_clk change to sample_valid.
REQ-027 bit_cnt SHALL be clog2(SAMPLE_W+1) bits wide and saturate at SAMPLE_W; it SHALL never wrap.

Reset
REQ-028 Reset SHALL asynchronously clear audio_left, audio_right, the holding register, shift_reg, bit_cnt, left_ok, sample_valid, frame_err and all synchroniser flops to 0, and set the FSM to IDLE.
REQ-029 Reset asserted mid-slot SHALL abort the word; after release, no sample_valid SHALL occur before one full left+right frame following the first l_r_clk edge.

Structure
REQ-030 Shared package audio_pkg SHALL hold the constant AUDIO_W=16 (the SAMPLE_W default) and the enum i2s_rx_state_t {IDLE, SHIFT, HOLD}.
REQ-031 A sub-module sync_ff (parameterised depth, one bit, async active-low reset) SHALL be instantiated three times; edge detection stays in i2s_rx.

Verification
REQ-032 Scenario: 32-bit slots, left 0x1234, right 0xABCD -> audio_left=0x1234, audio_right=0xABCD, one sample_valid, frame_err=0.
REQ-033 Scenario: right word 0x8000 -> audio_right reads -32768, confirming sign is preserved.
REQ-034 Scenario: 8-bit left slot carrying 0xA5 -> committed 0xA500 and one frame_err pulse.
REQ-035 Scenario: reset released mid-right-slot -> partial right word dropped; first sample_valid only after the next complete left+right frame.
REQ-036 Scenario: 4 back-to-back frames with incrementing values -> exactly 4 sample_valid pulses, each at latency SYNC_STAGES+2, values in order.
REQ-037 Scenario: reset asserted mid-left-slot at a random clk phase -> all outputs read 0 immediately, without waiting for a clk edge.
